// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: Avalon-MM bus between the arbiter (master) and memory (slave)
interface mem_bus_arbiter_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  modport master (output address, read, write, writedata, byteenable, input waitrequest, readdata);
  modport slave  (input address, read, write, writedata, byteenable, output waitrequest, readdata);
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one Avalon master between fetch (F) and data (D) with bounded F starvation
module mem_bus_arbiter #(
  parameter int STREAK_MAX = 4,
  parameter int STREAK_W   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_done,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic        d_done,
  output logic [31:0] d_rdata,
  mem_bus_arbiter_if.master bus,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STREAK_MAX);
  state_t state, state_n;
  logic owner_d, grant_d;
  logic [STREAK_W-1:0] streak;
  logic [31:0] sel_addr;
  always_comb begin
    grant_d  = d_req & ~(f_req & (streak == STREAK_LIM));
    sel_addr = grant_d ? d_addr : f_addr;
    state_n  = state == IDLE   ? ((f_req | d_req) ? ACCESS : IDLE)
             : state == ACCESS ? (bus.waitrequest ? ACCESS : DONE)
             : IDLE;
    busy     = state != IDLE;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // A D grant with F waiting implies streak < STREAK_LIM, so the increment never overshoots
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_d        <= 1'b0;
      streak         <= '0;
      f_done         <= 1'b0;
      d_done         <= 1'b0;
      f_rdata        <= '0;
      d_rdata        <= '0;
      bus.address    <= '0;
      bus.read       <= 1'b0;
      bus.write      <= 1'b0;
      bus.writedata  <= '0;
      bus.byteenable <= '0;
    end else begin
      f_done <= 1'b0;
      d_done <= 1'b0;
      if (state == IDLE) streak <= (f_req & grant_d) ? streak + STREAK_W'(1) : '0;
      if (state == IDLE && (f_req | d_req)) begin
        owner_d        <= grant_d;
        bus.read       <= ~(grant_d & d_write);
        bus.write      <= grant_d & d_write;
        bus.byteenable <= grant_d ? d_byteenable : 4'hf;
        bus.address    <= sel_addr & ~32'h3;
        if (grant_d) bus.writedata <= d_wdata;
      end
      if (state == ACCESS && !bus.waitrequest) begin
        bus.read  <= 1'b0;
        bus.write <= 1'b0;
        f_done    <= ~owner_d;
        d_done    <= owner_d;
        if (bus.read && owner_d) d_rdata <= bus.readdata;
        if (bus.read && !owner_d) f_rdata <= bus.readdata;
      end
    end
  end
endmodule
